// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmit controller.
//   state_t        : controller state encoding (IDLE / SHIFT)
//   bit_cnt_width  : width of the bit-position counter for a given word width
//   div_cnt_width  : width of the bit-period divider counter for a given DIV
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // bit_cnt must hold WIDTH-1. The guard only keeps the function defined
  // for out-of-range widths, which the controller rejects at elaboration.
  function automatic int bit_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // div_cnt must hold DIV-1; DIV=1 and DIV=2 still get one bit so the
  // vector never collapses to zero width.
  function automatic int div_cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit parallel-in/serial-out shift register, MSB first.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset, clears the register
//   load       : load load_data (has priority over shift_en)
//   shift_en   : shift left by one, zero fills the LSB
//   load_data  : parallel word to load
//   msb        : current register MSB (the bit on the serial line)
module piso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg <= '0;
    end else if (load) begin
      shreg_reg <= load_data;
    end else if (shift_en) begin
      shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg_reg[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Sequencing controller for the PISO shifter: accepts a parallel word over
// a valid/ready handshake, loads it into piso_shreg and holds each bit on
// the serial line for DIV clocks, MSB first.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (priority over everything)
//   in_data    : parallel word, captured on the handshake
//   in_valid   : producer has a word
//   in_ready   : controller is idle and can accept a word
//   flush      : abort the current frame (no done pulse)
//   ser_out    : serial data, forced to 0 when ser_valid is low
//   ser_valid  : ser_out carries a frame bit
//   ser_first  : current bit is the MSB of the frame
//   done       : one-cycle pulse after a frame completes normally
// All outputs are registers or decodes of registered state only.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             done
);

  localparam int BIT_W = bit_cnt_width(WIDTH);
  localparam int DIV_W = div_cnt_width(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((DIV < 1) ? 0 : DIV - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("piso_tx_ctrl: WIDTH must be at least 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("piso_tx_ctrl: DIV must be at least 1");
  end

  state_t           state_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             done_reg;

  logic             in_shift;
  logic             handshake;
  logic             bit_end;
  logic             abort;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_data;
  logic             sh_msb;

  assign in_shift  = (state_reg == SHIFT);
  // in_ready is exactly "state is IDLE", so the handshake needs only in_valid.
  assign handshake = !in_shift && in_valid;
  // Last clock of the current bit period.
  assign bit_end   = in_shift && (div_cnt_reg == '0);
  // flush matters only mid-frame; in IDLE it must not block a handshake.
  assign abort     = in_shift && flush;

  // A flush reuses the load path with an all-zero word to clear the shifter.
  assign sh_load   = handshake || abort;
  assign sh_data   = abort ? '0 : in_data;
  assign sh_shift  = bit_end && !flush && (bit_cnt_reg != '0);

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .shift_en  (sh_shift),
    .load_data (sh_data),
    .msb       (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= BIT_LAST;
            div_cnt_reg <= DIV_LAST;
          end
        end
        SHIFT: begin
          if (flush) begin
            // Abort beats a normal completion on the same edge.
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
          end else if (div_cnt_reg != '0) begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end else if (bit_cnt_reg != '0) begin
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
            div_cnt_reg <= DIV_LAST;
          end else begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = !in_shift;
  assign ser_valid = in_shift;
  assign ser_out   = in_shift && sh_msb;
  assign ser_first = in_shift && (bit_cnt_reg == BIT_LAST);
  assign done      = done_reg;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl. Two instances (DIV=1 and DIV=3) share
// the same stimulus. A reference model turns every accepted word into the
// list of per-cycle observations it must produce (WIDTH*DIV bit cycles plus
// a done cycle) and queues them; a monitor on the falling edge compares the
// DUT outputs against the expected observation of the current cycle.
module tb_piso_tx_ctrl;

  localparam int W  = 4;
  localparam int NI = 2;

  typedef struct packed {
    logic in_ready;
    logic ser_valid;
    logic ser_out;
    logic ser_first;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{in_ready: 1'b1, default: 1'b0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic [NI-1:0] in_ready;
  logic [NI-1:0] ser_out;
  logic [NI-1:0] ser_valid;
  logic [NI-1:0] ser_first;
  logic [NI-1:0] done;

  int n_cmp = 0;
  int n_err = 0;

  initial forever #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    piso_tx_ctrl #(
      .WIDTH(W),
      .DIV  ((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready[gi]),
      .flush     (flush),
      .ser_out   (ser_out[gi]),
      .ser_valid (ser_valid[gi]),
      .ser_first (ser_first[gi]),
      .done      (done[gi])
    );
  end

  // Reference model: expected observation for the cycle after each edge.
  obs_t cur [NI];
  obs_t fut [NI][$];
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    obs_t o;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        fut[i].delete();
        cur[i] = IDLE_OBS;
      end else if (cur[i].ser_valid && flush) begin
        fut[i].delete();
        cur[i] = IDLE_OBS;
      end else if (cur[i].in_ready && in_valid) begin
        // Word accepted: bit b (MSB first) is held for DIV cycles.
        for (int b = 0; b < W; b++) begin
          for (int d = 0; d < div_of(i); d++) begin
            o           = '0;
            o.ser_valid = 1'b1;
            o.ser_out   = in_data[W-1-b];
            o.ser_first = (b == 0);
            fut[i].push_back(o);
          end
        end
        o          = '0;
        o.done     = 1'b1;
        o.in_ready = 1'b1;
        fut[i].push_back(o);
        cur[i] = fut[i].pop_front();
      end else if (fut[i].size() > 0) begin
        cur[i] = fut[i].pop_front();
      end else begin
        cur[i] = IDLE_OBS;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  task automatic check(input string nm, input int i, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d (DIV=%0d) t=%0t: got %b expected %b",
               nm, i, div_of(i), $time, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge and compare.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("in_ready",  i, in_ready[i],  cur[i].in_ready);
        check("ser_valid", i, ser_valid[i], cur[i].ser_valid);
        check("ser_out",   i, ser_out[i],   cur[i].ser_out);
        check("ser_first", i, ser_first[i], cur[i].ser_first);
        check("done",      i, done[i],      cur[i].done);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Single words (DIV=1 and DIV=3 instances see the same words).
    send(4'b1011);
    cyc(16);
    send(4'b1001);
    cyc(16);

    // Back-to-back with in_valid held high.
    in_data  = 4'hA;
    in_valid = 1'b1;
    cyc(1);
    in_data  = 4'h5;
    cyc(6);
    in_valid = 1'b0;
    cyc(20);

    // flush in cycle 2 of a frame.
    send(4'b1111);
    cyc(1);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(16);

    // flush on the last bit cycle of the DIV=1 frame.
    send(4'b1101);
    cyc(3);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(16);

    // flush on the last bit cycle of the DIV=3 frame.
    send(4'b0111);
    cyc(11);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(16);

    // flush while idle together with a handshake.
    flush = 1'b1;
    send(4'b1100);
    flush = 1'b0;
    cyc(16);

    // Reset mid-frame (cycle 3), then a fresh word.
    send(4'b1110);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    send(4'b0110);
    cyc(16);

    // in_valid high with in_data changing every cycle.
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_data = W'($urandom);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(16);

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      flush    = ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
